// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide memory bus controller: bus direction levels,
// requester ids and sequencer states.
package mem_ctrl_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam logic READ_SIGNAL  = 1'b1;
  localparam logic WRITE_SIGNAL = 1'b0;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Index of the final beat; the illegal size code 2 behaves as a word.
  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    return (size == 2'd2) ? 2'd3 : size;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory bus master arbitrating IF refills against LS accesses;
// assembles little-endian read words and serialises store bytes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_r_nw
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("mem_ctrl: only RD_LAT=1 is supported");
  end

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  src_e              src_q, src_d;
  src_e              last_grant_q, last_grant_d;
  word_t             wdata_q, wdata_d;
  word_t             asm_q, asm_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  byte_t             mem_dout_q, mem_dout_d;
  logic              mem_r_nw_q, mem_r_nw_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  word_t             if_data_q, if_data_d;
  word_t             ls_rdata_q, ls_rdata_d;

  logic              grant_valid;
  src_e              grant_src;
  logic              grant_we;
  logic [1:0]        cnt_inc;

  // Round-robin only matters on a tie: the side not served last wins.
  always_comb begin
    grant_valid = if_req | ls_req;
    if (if_req && ls_req) begin
      grant_src = (last_grant_q == SRC_IF) ? SRC_LS : SRC_IF;
    end else if (if_req) begin
      grant_src = SRC_IF;
    end else begin
      grant_src = SRC_LS;
    end
    grant_we = (grant_src == SRC_LS) && ls_we;
    cnt_inc  = cnt_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      base_q       <= '0;
      src_q        <= SRC_IF;
      last_grant_q <= SRC_IF;
      wdata_q      <= '0;
      asm_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_r_nw_q   <= READ_SIGNAL;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      if_data_q    <= '0;
      ls_rdata_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      base_q       <= base_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_r_nw_q   <= mem_r_nw_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
      if_data_q    <= if_data_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_valid) state_d = grant_we ? ST_WR : ST_RD;
      ST_RD:   if (cnt_q == last_q) state_d = ST_DONE;
      ST_WR:   if (cnt_q == last_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    last_d       = last_q;
    base_d       = base_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_r_nw_d   = READ_SIGNAL;
    if_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    if_data_d    = if_data_q;
    ls_rdata_d   = ls_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          base_d  = (grant_src == SRC_IF) ? if_addr : ls_addr;
          last_d  = (grant_src == SRC_IF) ? 2'd3 : size_to_last(ls_size);
          src_d   = grant_src;
          wdata_d = ls_wdata;
          mem_a_d = base_d;
          cnt_d   = '0;
          asm_d   = '0;
          if (grant_we) begin
            mem_dout_d = ls_wdata[7:0];
            mem_r_nw_d = WRITE_SIGNAL;
          end
        end
      end
      ST_RD: begin
        asm_d[{cnt_q, 3'b000} +: 8] = mem_din;
        if (cnt_q == last_q) begin
          if (src_q == SRC_IF) begin
            if_data_d = asm_d;
            if_done_d = 1'b1;
          end else begin
            ls_rdata_d = asm_d;
            ls_done_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_inc;
          mem_a_d = base_q + ADDR_W'(cnt_inc);
        end
      end
      ST_WR: begin
        if (cnt_q == last_q) begin
          if (src_q == SRC_IF) if_done_d = 1'b1;
          else                 ls_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          mem_a_d    = base_q + ADDR_W'(cnt_inc);
          mem_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
          mem_r_nw_d = WRITE_SIGNAL;
        end
      end
      ST_DONE: begin
        last_grant_d = src_q;
      end
      default: ;
    endcase
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_r_nw = mem_r_nw_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model on the bus, hand-computed
// expectations for reads, stores, arbitration, stalls and resets.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_r_nw;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  ram [0:255];
  logic        loaded = 1'b0;
  int unsigned wr_cycles = 0;
  int unsigned ls_done_cnt = 0;

  mem_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_r_nw(mem_r_nw)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[7:0]];

  // Byte RAM: preloaded on the first edge, written on edges while the bus says WRITE.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[8'h00] = 8'h13; ram[8'h01] = 8'h05;
      ram[8'h07] = 8'h34; ram[8'h08] = 8'h12;
      ram[8'hFE] = 8'hAA; ram[8'hFF] = 8'hBB;
      loaded = 1'b1;
    end else if (!rst) begin
      if (mem_r_nw == 1'b0) begin
        ram[mem_a[7:0]] = mem_dout;
        wr_cycles++;
      end
      if (ls_done) ls_done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_if, output int unsigned lat);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (is_if ? if_done : ls_done) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned cyc;
    int unsigned ws;
    int unsigned ds;
    int unsigned n;
    int unsigned guard;
    int unsigned both;
    int unsigned stray;
    logic [3:0]  order;

    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_r_nw", {31'b0, mem_r_nw}, 32'h1);
    check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_dones", {30'b0, if_done, ls_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // IF word refill with per-beat address check
    if_addr = 32'h1000; if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("if_mem_a", mem_a, 32'h1000 + i);
    end
    tick();
    check("if_done_lat5", {31'b0, if_done}, 32'h1);
    check("if_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    check("if_done_pulse", {31'b0, if_done}, 32'h0);

    // store word
    ws = wr_cycles; ds = ls_done_cnt;
    ls_we = 1'b1; ls_size = 2'd3; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
    tick();
    check("st_first_a", mem_a, 32'h20);
    check("st_first_dout", {24'b0, mem_dout}, 32'hEF);
    check("st_first_rnw", {31'b0, mem_r_nw}, 32'h0);
    wait_done(1'b0, lat);
    check("st_lat", lat, 32'd4);
    check("st_rnw_done", {31'b0, mem_r_nw}, 32'h1);
    ls_req = 1'b0; ls_we = 1'b0;
    tick();
    check("st_ram", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'hDEAD_BEEF);
    check("st_wr_cycles", wr_cycles - ws, 32'd4);
    check("st_done_once", ls_done_cnt - ds, 32'd1);

    // half load at odd address
    ls_size = 2'd1; ls_addr = 32'h7; ls_req = 1'b1;
    wait_done(1'b0, lat);
    check("half_lat", lat, 32'd3);
    check("half_data", ls_rdata, 32'h0000_1234);
    ls_req = 1'b0;
    tick();

    // byte load, zero-extended
    ls_size = 2'd0; ls_addr = 32'h8; ls_req = 1'b1;
    wait_done(1'b0, lat);
    check("byte_lat", lat, 32'd2);
    check("byte_data", ls_rdata, 32'h0000_0012);
    ls_req = 1'b0;
    tick();

    // illegal size 2 behaves as word
    ls_size = 2'd2; ls_addr = 32'h20; ls_req = 1'b1;
    wait_done(1'b0, lat);
    check("sz2_lat", lat, 32'd5);
    check("sz2_data", ls_rdata, 32'hDEAD_BEEF);
    ls_req = 1'b0;
    tick();

    // word load across the 2^32 wrap
    ls_size = 2'd3; ls_addr = 32'hFFFF_FFFE; ls_req = 1'b1;
    wait_done(1'b0, lat);
    check("wrap_lat", lat, 32'd5);
    check("wrap_data", ls_rdata, 32'h0513_BBAA);
    check("wrap_last_a", mem_a, 32'h0000_0001);
    ls_req = 1'b0;
    tick();

    // both requesting continuously; LS was served last so IF goes first
    if_addr = 32'h1000; ls_size = 2'd0; ls_addr = 32'h7;
    if_req = 1'b1; ls_req = 1'b1;
    order = '0; n = 0; guard = 0; both = 0;
    while (n < 4 && guard < 80) begin
      tick();
      guard++;
      if (if_done && ls_done) both++;
      if (if_done || ls_done) begin
        order = {order[2:0], if_done};
        n++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("arb_count", n, 32'd4);
    check("arb_order", {28'b0, order}, 32'b1010);
    check("arb_no_overlap", both, 32'd0);
    check("arb_ls_data", ls_rdata, 32'h0000_0034);
    tick();

    // stall three cycles while byte 2 of an IF read is on the bus
    if_addr = 32'h1000; if_req = 1'b1;
    repeat (3) tick();
    cyc = 3;
    check("stall_a_before", mem_a, 32'h1002);
    rdy = 1'b0;
    repeat (3) begin
      tick();
      cyc++;
      check("stall_a_frozen", mem_a, 32'h1002);
    end
    rdy = 1'b1;
    wait_done(1'b1, lat);
    check("stall_lat", cyc + lat, 32'd8);
    check("stall_data", if_data, 32'h0000_0513);
    rdy = 1'b0; if_req = 1'b0;
    tick();
    check("done_extend", {31'b0, if_done}, 32'h1);
    rdy = 1'b1;
    tick();
    check("done_release", {31'b0, if_done}, 32'h0);
    tick();

    // async reset in the middle of a refill
    if_req = 1'b1;
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_a", mem_a, 32'h0);
    check("mid_rst_rnw", {31'b0, mem_r_nw}, 32'h1);
    check("mid_rst_if_data", if_data, 32'h0);
    check("mid_rst_ls_rdata", ls_rdata, 32'h0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      tick();
      if (if_done || ls_done) stray++;
    end
    check("mid_rst_no_done", stray, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
